// File: rtl/hazard_scoreboard_unit.sv
// Stall/flush control for the 5-stage pipeline: load-use, long-latency register
// scoreboard, data-memory freeze and taken-branch flush, with a stall-cycle counter.
module hazard_scoreboard_unit #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STALL_CNT_W     = 16
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic [4:0]             in_ifid_rs1,
    input  logic [4:0]             in_ifid_rs2,
    input  logic                   in_ifid_uses_rs1,
    input  logic                   in_ifid_uses_rs2,
    input  logic                   in_ifid_longlat,
    input  logic [4:0]             in_ifid_rd,
    input  logic                   in_idex_memread,
    input  logic [4:0]             in_idex_rd,
    input  logic                   in_wb_longlat_valid,
    input  logic [4:0]             in_wb_longlat_rd,
    input  logic                   in_branch_taken,
    input  logic                   in_mem_busy,
    output logic                   out_pc_write,
    output logic                   out_ifid_write,
    output logic                   out_ifid_flush,
    output logic                   out_idex_bubble,
    output logic                   out_exmem_hold,
    output logic [31:0]            out_pending,
    output logic [2:0]             out_pending_cnt,
    output logic [STALL_CNT_W-1:0] out_stall_cnt
);

    // state     | meaning
    // ST_RUN    | normal operation
    // ST_FREEZE | data memory busy, whole pipeline held
    // ST_FLUSH  | branch seen during a freeze, flush IF/ID now
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic                   flush_pending, flush_pending_nxt;
    logic [31:0]            pending, pending_nxt;
    logic [2:0]             pending_cnt;
    logic [STALL_CNT_W-1:0] stall_cnt;
    logic                   load_use, sb_hit, sb_full, waw, data_stall, issue;
    logic                   pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold;

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            pending_cnt = pending_cnt + {2'b00, pending[i]};
        end
    end

    assign load_use = in_idex_memread && (in_idex_rd != 5'd0) &&
                      ((in_ifid_uses_rs1 && (in_ifid_rs1 == in_idex_rd)) ||
                       (in_ifid_uses_rs2 && (in_ifid_rs2 == in_idex_rd)));
    assign sb_hit     = (in_ifid_uses_rs1 && pending[in_ifid_rs1]) ||
                        (in_ifid_uses_rs2 && pending[in_ifid_rs2]);
    assign sb_full    = in_ifid_longlat && (pending_cnt == 3'(MAX_OUTSTANDING));
    assign waw        = in_ifid_longlat && pending[in_ifid_rd] && (in_ifid_rd != 5'd0);
    assign data_stall = load_use || sb_hit || sb_full || waw;

    // Outputs are Mealy: hazards must stall the instruction in the same cycle it sits in ID.
    always_comb begin
        pc_write          = 1'b1;
        ifid_write        = 1'b1;
        ifid_flush        = 1'b0;
        idex_bubble       = 1'b0;
        exmem_hold        = 1'b0;
        state_nxt         = state;
        flush_pending_nxt = flush_pending;
        if (in_rst) begin
            state_nxt         = ST_RUN;
            flush_pending_nxt = 1'b0;
        end else if (in_mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            exmem_hold = 1'b1;
            state_nxt  = ST_FREEZE;
            if (in_branch_taken) begin
                flush_pending_nxt = 1'b1;
            end
        end else if ((state == ST_FLUSH) || in_branch_taken) begin
            ifid_flush        = 1'b1;
            idex_bubble       = 1'b1;
            state_nxt         = ST_RUN;
            flush_pending_nxt = 1'b0;
        end else begin
            if (data_stall) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
            // A branch latched during the freeze is flushed one cycle after busy drops.
            state_nxt = ((state == ST_FREEZE) && flush_pending) ? ST_FLUSH : ST_RUN;
        end
    end

    assign issue = pc_write && ifid_write && !idex_bubble && !ifid_flush;

    always_comb begin
        pending_nxt = pending;
        if (in_wb_longlat_valid && (in_wb_longlat_rd != 5'd0)) begin
            pending_nxt[in_wb_longlat_rd] = 1'b0;
        end
        if (issue && in_ifid_longlat && (in_ifid_rd != 5'd0)) begin
            pending_nxt[in_ifid_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state         <= ST_RUN;
            flush_pending <= 1'b0;
            pending       <= '0;
            stall_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            flush_pending <= flush_pending_nxt;
            pending       <= pending_nxt;
            if (!pc_write && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_pc_write    = pc_write;
    assign out_ifid_write  = ifid_write;
    assign out_ifid_flush  = ifid_flush;
    assign out_idex_bubble = idex_bubble;
    assign out_exmem_hold  = exmem_hold;
    assign out_pending     = pending;
    assign out_pending_cnt = pending_cnt;
    assign out_stall_cnt   = stall_cnt;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: vector table, directed multi-cycle sequences
// and random traffic compared against a flag/array reference model.
module tb_hazard_scoreboard_unit;

    logic        in_clk = 1'b0;
    logic        in_rst;
    logic [4:0]  in_ifid_rs1, in_ifid_rs2, in_ifid_rd, in_idex_rd, in_wb_longlat_rd;
    logic        in_ifid_uses_rs1, in_ifid_uses_rs2, in_ifid_longlat, in_idex_memread;
    logic        in_wb_longlat_valid, in_branch_taken, in_mem_busy;
    logic        out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble, out_exmem_hold;
    logic [31:0] out_pending;
    logic [2:0]  out_pending_cnt;
    logic [15:0] out_stall_cnt;

    hazard_scoreboard_unit #(.MAX_OUTSTANDING(4), .STALL_CNT_W(16)) dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .in_ifid_rs1(in_ifid_rs1), .in_ifid_rs2(in_ifid_rs2),
        .in_ifid_uses_rs1(in_ifid_uses_rs1), .in_ifid_uses_rs2(in_ifid_uses_rs2),
        .in_ifid_longlat(in_ifid_longlat), .in_ifid_rd(in_ifid_rd),
        .in_idex_memread(in_idex_memread), .in_idex_rd(in_idex_rd),
        .in_wb_longlat_valid(in_wb_longlat_valid), .in_wb_longlat_rd(in_wb_longlat_rd),
        .in_branch_taken(in_branch_taken), .in_mem_busy(in_mem_busy),
        .out_pc_write(out_pc_write), .out_ifid_write(out_ifid_write),
        .out_ifid_flush(out_ifid_flush), .out_idex_bubble(out_idex_bubble),
        .out_exmem_hold(out_exmem_hold), .out_pending(out_pending),
        .out_pending_cnt(out_pending_cnt), .out_stall_cnt(out_stall_cnt)
    );

    always #5 in_clk = ~in_clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd, idex_rd, wb_rd;
        logic       u1, u2, ll, mr, wbv, br, busy;
    } vec_t;

    // exp = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold}
    typedef struct {
        vec_t       in;
        logic [4:0] exp;
    } tv_t;

    int total = 0;
    int bad   = 0;

    // Reference model: a register-pending array plus three behavioural flags.
    bit          m_pend[32];
    bit          m_frozen, m_defer, m_flushcyc;
    int unsigned m_stall;
    logic        e_pc, e_ifid, e_flush, e_bub, e_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t nv();
        vec_t v;
        v.rs1 = 5'd0; v.rs2 = 5'd0; v.rd = 5'd0; v.idex_rd = 5'd0; v.wb_rd = 5'd0;
        v.u1 = 1'b0; v.u2 = 1'b0; v.ll = 1'b0; v.mr = 1'b0; v.wbv = 1'b0; v.br = 1'b0; v.busy = 1'b0;
        return v;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
        return c;
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] r = '0;
        for (int i = 0; i < 32; i++) r[i] = m_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_frozen = 1'b0; m_defer = 1'b0; m_flushcyc = 1'b0; m_stall = 0;
    endtask

    task automatic model_eval(input vec_t v);
        bit lu, hit, full, waw;
        lu   = v.mr && (v.idex_rd != 0) &&
               ((v.u1 && v.rs1 == v.idex_rd) || (v.u2 && v.rs2 == v.idex_rd));
        hit  = (v.u1 && m_pend[v.rs1]) || (v.u2 && m_pend[v.rs2]);
        full = v.ll && (m_count() == 4);
        waw  = v.ll && (v.rd != 0) && m_pend[v.rd];
        if (v.busy)                 {e_pc, e_ifid, e_flush, e_bub, e_hold} = 5'b00001;
        else if (m_flushcyc || v.br) {e_pc, e_ifid, e_flush, e_bub, e_hold} = 5'b11110;
        else if (lu || hit || full || waw) {e_pc, e_ifid, e_flush, e_bub, e_hold} = 5'b00010;
        else                        {e_pc, e_ifid, e_flush, e_bub, e_hold} = 5'b11000;
    endtask

    task automatic model_update(input vec_t v);
        if (v.wbv && v.wb_rd != 0) m_pend[v.wb_rd] = 1'b0;
        if (e_pc && e_ifid && !e_bub && !e_flush && v.ll && v.rd != 0) m_pend[v.rd] = 1'b1;
        if (!e_pc && m_stall < 65535) m_stall++;
        if (v.busy) begin
            m_defer    = m_defer | v.br | m_flushcyc;
            m_flushcyc = 1'b0;
            m_frozen   = 1'b1;
        end else if (m_flushcyc || v.br) begin
            m_flushcyc = 1'b0; m_defer = 1'b0; m_frozen = 1'b0;
        end else begin
            m_flushcyc = m_frozen && m_defer;
            m_defer    = 1'b0;
            m_frozen   = 1'b0;
        end
    endtask

    task automatic set_inputs(input vec_t v);
        in_ifid_rs1 = v.rs1; in_ifid_rs2 = v.rs2; in_ifid_rd = v.rd;
        in_ifid_uses_rs1 = v.u1; in_ifid_uses_rs2 = v.u2; in_ifid_longlat = v.ll;
        in_idex_memread = v.mr; in_idex_rd = v.idex_rd;
        in_wb_longlat_valid = v.wbv; in_wb_longlat_rd = v.wb_rd;
        in_branch_taken = v.br; in_mem_busy = v.busy;
    endtask

    task automatic drive_cycle(input vec_t v, input string tag, input bit use_exp, input logic [4:0] exp_ctrl);
        @(negedge in_clk);
        set_inputs(v);
        #1;
        model_eval(v);
        chk({tag, ".ctrl"}, {27'd0, out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble, out_exmem_hold},
            {27'd0, e_pc, e_ifid, e_flush, e_bub, e_hold});
        chk({tag, ".pending"}, out_pending, m_vec());
        chk({tag, ".cnt"}, {29'd0, out_pending_cnt}, 32'(m_count()));
        chk({tag, ".stall"}, {16'd0, out_stall_cnt}, m_stall);
        if (use_exp) begin
            chk({tag, ".exp"}, {27'd0, out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble, out_exmem_hold},
                {27'd0, exp_ctrl});
        end
        @(posedge in_clk);
        model_update(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".ctrl"}, {27'd0, out_pc_write, out_ifid_write, out_ifid_flush, out_idex_bubble, out_exmem_hold},
            32'b11000);
        chk({tag, ".pending"}, out_pending, 32'd0);
        chk({tag, ".cnt"}, {29'd0, out_pending_cnt}, 32'd0);
        chk({tag, ".stall"}, {16'd0, out_stall_cnt}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge in_clk);
        in_rst = 1'b1;
        set_inputs(nv());
        repeat (2) @(posedge in_clk);
        @(negedge in_clk);
        #1;
        chk_reset_vals(tag);
        in_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tv_t  tbl[8];
        vec_t v;
        logic [31:0] rd_list;

        in_rst = 1'b1;
        set_inputs(nv());
        model_reset();

        // Single-cycle vector table (scoreboard empty, no freeze).
        for (int i = 0; i < 8; i++) begin tbl[i].in = nv(); tbl[i].exp = 5'b11000; end
        tbl[1].in.mr = 1; tbl[1].in.idex_rd = 5; tbl[1].in.u1 = 1; tbl[1].in.rs1 = 5; tbl[1].exp = 5'b00010;
        tbl[2].in.mr = 1; tbl[2].in.idex_rd = 6; tbl[2].in.u2 = 1; tbl[2].in.rs2 = 6; tbl[2].exp = 5'b00010;
        tbl[3].in.mr = 1; tbl[3].in.idex_rd = 0; tbl[3].in.u1 = 1; tbl[3].in.rs1 = 0;
        tbl[4].in.mr = 1; tbl[4].in.idex_rd = 5; tbl[4].in.u1 = 0; tbl[4].in.rs1 = 5;
        tbl[5].in.mr = 0; tbl[5].in.idex_rd = 5; tbl[5].in.u1 = 1; tbl[5].in.rs1 = 5;
        tbl[6].in.mr = 1; tbl[6].in.idex_rd = 5; tbl[6].in.u1 = 1; tbl[6].in.rs1 = 5; tbl[6].in.br = 1;
        tbl[6].exp = 5'b11110;
        tbl[7].in.br = 1; tbl[7].exp = 5'b11110;

        do_reset("reset");
        for (int i = 0; i < 8; i++) drive_cycle(tbl[i].in, $sformatf("table%0d", i), 1'b1, tbl[i].exp);

        // Load-use: one stall cycle then proceed.
        do_reset("lu_reset");
        v = nv(); v.mr = 1; v.idex_rd = 5; v.u1 = 1; v.rs1 = 5;
        drive_cycle(v, "lu_stall", 1'b1, 5'b00010);
        v.mr = 0;
        drive_cycle(v, "lu_go", 1'b1, 5'b11000);
        #1 chk("lu_stall_cnt", {16'd0, out_stall_cnt}, 32'd1);

        // Scoreboard set / wait / clear without same-cycle bypass.
        do_reset("sb_reset");
        v = nv(); v.ll = 1; v.rd = 7;
        drive_cycle(v, "sb_issue", 1'b1, 5'b11000);
        #1 chk("sb_pending", out_pending, 32'h80);
        chk("sb_cnt", {29'd0, out_pending_cnt}, 32'd1);
        v = nv(); v.u2 = 1; v.rs2 = 7;
        drive_cycle(v, "sb_wait1", 1'b1, 5'b00010);
        drive_cycle(v, "sb_wait2", 1'b1, 5'b00010);
        v.wbv = 1; v.wb_rd = 7;
        drive_cycle(v, "sb_clear", 1'b1, 5'b00010);
        v.wbv = 0;
        drive_cycle(v, "sb_go", 1'b1, 5'b11000);
        #1 chk("sb_pending_clr", out_pending, 32'h0);

        // Scoreboard full, then a retire frees a slot.
        do_reset("full_reset");
        for (int r = 1; r <= 4; r++) begin
            v = nv(); v.ll = 1; v.rd = 5'(r);
            drive_cycle(v, $sformatf("full_issue%0d", r), 1'b1, 5'b11000);
        end
        #1 chk("full_cnt4", {29'd0, out_pending_cnt}, 32'd4);
        v = nv(); v.ll = 1; v.rd = 9;
        drive_cycle(v, "full_stall", 1'b1, 5'b00010);
        v.wbv = 1; v.wb_rd = 2;
        drive_cycle(v, "full_retire", 1'b1, 5'b00010);
        v.wbv = 0;
        drive_cycle(v, "full_issue9", 1'b1, 5'b11000);
        rd_list = 32'h21A;
        #1 chk("full_pending", out_pending, rd_list);
        chk("full_cnt_after", {29'd0, out_pending_cnt}, 32'd4);

        // Freeze with a branch in its second cycle, deferred flush afterwards.
        do_reset("frz_reset");
        v = nv(); v.busy = 1;
        drive_cycle(v, "frz1", 1'b1, 5'b00001);
        v.br = 1;
        drive_cycle(v, "frz2", 1'b1, 5'b00001);
        v.br = 0;
        drive_cycle(v, "frz3", 1'b1, 5'b00001);
        v = nv();
        drive_cycle(v, "frz_drop", 1'b1, 5'b11000);
        drive_cycle(v, "frz_flush", 1'b1, 5'b11110);
        drive_cycle(v, "frz_run", 1'b1, 5'b11000);
        #1 chk("frz_stall_cnt", {16'd0, out_stall_cnt}, 32'd3);

        // Asynchronous reset in the middle of a freeze with a register pending.
        do_reset("ar_reset");
        v = nv(); v.ll = 1; v.rd = 7;
        drive_cycle(v, "ar_issue", 1'b1, 5'b11000);
        v = nv(); v.busy = 1;
        drive_cycle(v, "ar_frz", 1'b1, 5'b00001);
        @(negedge in_clk);
        #2;
        chk("ar_pre_pending", out_pending, 32'h80);
        in_rst = 1'b1;
        #1;
        chk_reset_vals("ar_async");
        @(negedge in_clk);
        set_inputs(nv());
        in_rst = 1'b0;
        model_reset();

        // Random traffic over a small register window so hazards are frequent.
        do_reset("rnd_reset");
        for (int n = 0; n < 3000; n++) begin
            v.rs1 = 5'($urandom_range(0, 7)); v.rs2 = 5'($urandom_range(0, 7));
            v.rd = 5'($urandom_range(0, 7)); v.idex_rd = 5'($urandom_range(0, 7));
            v.wb_rd = 5'($urandom_range(0, 7));
            v.u1 = ($urandom_range(0, 99) < 70); v.u2 = ($urandom_range(0, 99) < 50);
            v.ll = ($urandom_range(0, 99) < 30); v.mr = ($urandom_range(0, 99) < 30);
            v.wbv = ($urandom_range(0, 99) < 30); v.br = ($urandom_range(0, 99) < 10);
            v.busy = ($urandom_range(0, 99) < 20);
            drive_cycle(v, "rnd", 1'b0, 5'b00000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
